// File: rtl/fsm_step_sequencer.sv
// Command-driven four-phase step sequencer: advances `estados` once every DIV clocks
// for a requested number of steps, in either direction, with abort and completion pulses.
module fsm_step_sequencer #(
    parameter int DIV   = 100,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             abort,
    output logic [1:0]       estados,
    output logic             step_tick,
    output logic             busy,
    output logic [CNT_W-1:0] steps_left,
    output logic             done,
    output logic             aborted
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    // Two encodings are spare so that a corrupted state register has a defined way back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    state_t             state_r, state_s;
    logic [PW-1:0]      presc_r, presc_s;
    logic [1:0]         estados_r, estados_s;
    logic [CNT_W-1:0]   steps_left_r, steps_left_s;
    logic               dir_r, dir_s;
    logic               step_tick_r, step_tick_s;
    logic               done_r, done_s;
    logic               aborted_r, aborted_s;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            presc_r      <= {PW{1'b0}};
            estados_r    <= 2'd0;
            steps_left_r <= {CNT_W{1'b0}};
            dir_r        <= 1'b0;
            step_tick_r  <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            presc_r      <= presc_s;
            estados_r    <= estados_s;
            steps_left_r <= steps_left_s;
            dir_r        <= dir_s;
            step_tick_r  <= step_tick_s;
            done_r       <= done_s;
            aborted_r    <= aborted_s;
        end
    end

    // Next-state and next-output logic; abort outranks a coincident step edge.
    always_comb begin
        state_s      = state_r;
        presc_s      = presc_r;
        estados_s    = estados_r;
        steps_left_s = steps_left_r;
        dir_s        = dir_r;
        step_tick_s  = 1'b0;
        done_s       = 1'b0;
        aborted_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && !abort) begin
                    if (cmd_steps == {CNT_W{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        dir_s        = cmd_dir;
                        steps_left_s = cmd_steps;
                        presc_s      = {PW{1'b0}};
                        state_s      = RUN;
                    end
                end else begin
                    presc_s = {PW{1'b0}};
                end
            end
            RUN: begin
                if (abort) begin
                    state_s   = IDLE;
                    presc_s   = {PW{1'b0}};
                    aborted_s = 1'b1;
                end else if (presc_r == PRESC_MAX) begin
                    presc_s      = {PW{1'b0}};
                    estados_s    = dir_r ? (estados_r - 2'd1) : (estados_r + 2'd1);
                    steps_left_s = steps_left_r - CNT_W'(1);
                    step_tick_s  = 1'b1;
                    if (steps_left_r == CNT_W'(1)) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                presc_s = {PW{1'b0}};
            end
        endcase
    end

    assign cmd_ready  = (state_r == IDLE);
    assign busy       = (state_r == RUN);
    assign estados    = estados_r;
    assign step_tick  = step_tick_r;
    assign steps_left = steps_left_r;
    assign done       = done_r;
    assign aborted    = aborted_r;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Directed bench for fsm_step_sequencer: expected phases are queued when a command is
// driven and popped whenever the sequencer reports a step.
module tb_fsm_step_sequencer;

    localparam int DIV   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic             abort;
    logic [1:0]       estados;
    logic             step_tick;
    logic             busy;
    logic [CNT_W-1:0] steps_left;
    logic             done;
    logic             aborted;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] model_est;

    fsm_step_sequencer #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
        .estados    (estados),
        .step_tick  (step_tick),
        .busy       (busy),
        .steps_left (steps_left),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the phases a move of n steps in direction d should produce.
    task automatic push_move(input int n, input logic d);
        for (int k = 0; k < n; k++) begin
            model_est = d ? model_est - 2'd1 : model_est + 2'd1;
            exp_q.push_back(model_est);
        end
    endtask

    // One clock; on every reported step, compare the phase against the queue head.
    task automatic step();
        logic [1:0] e;
        @(posedge clk);
        #1;
        if (step_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 32'(step_tick), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_estados", 32'(estados), 32'(e));
            end
        end
    endtask

    // Issue a nonzero move, run it to completion and check the pulse pattern.
    task automatic run_move(input int n, input logic d);
        cmd_valid = 1'b1;
        cmd_steps = CNT_W'(n);
        cmd_dir   = d;
        push_move(n, d);
        step();
        cmd_valid = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(cmd_ready), 32'd0);
        chk("accept_steps_left", 32'(steps_left), 32'(n));
        for (int i = 1; i <= n * DIV; i++) begin
            step();
            chk("tick_pattern", 32'(step_tick), 32'(i % DIV == 0));
            chk("done_pattern", 32'(done), 32'(i == n * DIV));
        end
        chk("end_steps_left", 32'(steps_left), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(cmd_ready), 32'd1);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        chk("post_done_low", 32'(done), 32'd0);
    endtask

    initial begin
        model_est = 2'd0;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd5;
        abort     = 1'b0;

        // 1. reset with a command pending
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_estados", 32'(estados), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_steps_left", 32'(steps_left), 32'd0);
            chk("rst_ready", 32'(cmd_ready), 32'd1);
        end
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        step();
        chk("rel_ready", 32'(cmd_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        // 2. forward move of 6 from phase 0
        run_move(6, 1'b0);
        chk("fwd_final_estados", 32'(estados), 32'd2);

        // 3. reverse move of 3 from phase 2, wrapping through 0
        run_move(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rev_hold_estados", 32'(estados), 32'd3);
        end

        // 4. zero-step command
        cmd_valid = 1'b1;
        cmd_steps = 8'd0;
        cmd_dir   = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_tick", 32'(step_tick), 32'd0);
        chk("zero_estados", 32'(estados), 32'd3);
        step();
        chk("zero_done_low", 32'(done), 32'd0);
        chk("zero_busy_later", 32'(busy), 32'd0);

        // 5. abort landing on the second step edge
        cmd_valid = 1'b1;
        cmd_steps = 8'd5;
        cmd_dir   = 1'b0;
        push_move(1, 1'b0);
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i < 2 * DIV; i++) begin
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_tick", 32'(step_tick), 32'd0);
        chk("abort_estados", 32'(estados), 32'd0);
        chk("abort_steps_left", 32'(steps_left), 32'd4);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        chk("abort_pulse_low", 32'(aborted), 32'd0);

        // 6. command held valid throughout a 2-step move
        cmd_valid = 1'b1;
        cmd_steps = 8'd2;
        cmd_dir   = 1'b0;
        push_move(2, 1'b0);
        step();
        cmd_steps = 8'd1;
        cmd_dir   = 1'b1;
        for (int i = 1; i <= 2 * DIV; i++) begin
            step();
            chk("hs_done_pattern", 32'(done), 32'(i == 2 * DIV));
            chk("hs_busy", 32'(busy), 32'(i != 2 * DIV));
            chk("hs_steps_left", 32'(steps_left), 32'(2 - i / DIV));
        end
        push_move(1, 1'b1);
        step();
        cmd_valid = 1'b0;
        chk("hs_second_busy", 32'(busy), 32'd1);
        chk("hs_second_steps", 32'(steps_left), 32'd1);
        chk("hs_second_done_low", 32'(done), 32'd0);
        for (int i = 1; i <= DIV; i++) begin
            step();
            chk("hs_second_tick", 32'(step_tick), 32'(i == DIV));
            chk("hs_second_done", 32'(done), 32'(i == DIV));
        end
        chk("hs_final_estados", 32'(estados), 32'd1);
        chk("hs_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
